// File: rtl/mio_bus_responder.sv
// Memory/IO-bus target for the multicycle CPU: word RAM or external IO window with wait states.
// Optional feature: define MIO_TIMEOUT_EN to build the IO ack timeout and the sticky bus_err flag.
module mio_bus_responder #(
    parameter int          RAM_AW     = 10,
    parameter int          RAM_LAT    = 2,
    parameter logic [3:0]  IO_NIB     = 4'hE,
    parameter int          IO_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        CPU_MIO,
    input  logic [31:0] addr_bus,
    input  logic [31:0] Data_out,
    input  logic [1:0]  Dout_ctrl,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic        io_req,
    output logic        io_we,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_be,
    input  logic [31:0] io_rdata,
    input  logic        io_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_REQ, DONE} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              is_io;
    logic [31:0]       mem [2**RAM_AW];
    logic [RAM_AW-1:0] idx;
    logic              req;
    logic [3:0]        be_next;
    logic [31:0]       wdata_next;

    assign req = CPU_MIO & (MemRead | MemWrite);
    // Upper RAM address bits are dropped, so the RAM aliases across the non-IO space.
    assign idx = io_addr[RAM_AW+1:2];

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = Data_out;
        case (Dout_ctrl)
            2'b01: begin
                be_next    = addr_bus[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{Data_out[15:0]}};
            end
            2'b10: begin
                be_next    = 4'b0001 << addr_bus[1:0];
                wdata_next = {4{Data_out[7:0]}};
            end
            default: ;
        endcase
    end

`ifdef MIO_TIMEOUT_EN
    localparam int TW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
    logic [TW-1:0] tcnt;
`else
    assign bus_err = 1'b0;
`endif

    // NOTE: state is updated with non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            is_io     <= 1'b0;
            MIO_ready <= 1'b0;
            io_req    <= 1'b0;
            io_we     <= 1'b0;
            io_addr   <= '0;
            io_wdata  <= '0;
            io_be     <= '0;
            Data_in   <= '0;
`ifdef MIO_TIMEOUT_EN
            tcnt      <= '0;
            bus_err   <= 1'b0;
`endif
        end else begin
            MIO_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        io_addr  <= addr_bus;
                        io_wdata <= wdata_next;
                        io_be    <= be_next;
                        io_we    <= MemWrite;
`ifdef MIO_TIMEOUT_EN
                        tcnt     <= '0;
`endif
                        if (addr_bus[31:28] >= IO_NIB) begin
                            is_io  <= 1'b1;
                            io_req <= 1'b1;
                            state  <= IO_REQ;
                        end else begin
                            is_io  <= 1'b0;
                            cnt    <= 4'(RAM_LAT);
                            state  <= RAM_WAIT;
                        end
                    end
                end
                RAM_WAIT: begin
                    if (cnt == 4'd0) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                IO_REQ: begin
                    if (io_ack) begin
                        io_req <= 1'b0;
                        if (!io_we) Data_in <= io_rdata;
                        state  <= DONE;
                    end
`ifdef MIO_TIMEOUT_EN
                    else if (tcnt == TW'(IO_TIMEOUT - 1)) begin
                        io_req  <= 1'b0;
                        bus_err <= 1'b1;
                        if (!io_we) Data_in <= 32'hDEAD_BEEF;
                        state   <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    MIO_ready <= 1'b1;
                    if (!is_io && !io_we) Data_in <= mem[idx];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset; its contents survive reset_n by design.
    always_ff @(posedge clk) begin
        if (state == DONE && !is_io && io_we) begin
            for (int b = 0; b < 4; b++) begin
                if (io_be[b]) mem[idx][8*b +: 8] <= io_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: RAM vector table plus IO, reset and handshake sequences.
module tb_mio_bus_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemRead, MemWrite, CPU_MIO;
    logic [31:0] addr_bus, Data_out;
    logic [1:0]  Dout_ctrl;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic        io_req, io_we;
    logic [31:0] io_addr, io_wdata;
    logic [3:0]  io_be;
    logic [31:0] io_rdata;
    logic        io_ack;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mio_bus_responder #(
        .RAM_AW(10), .RAM_LAT(2), .IO_NIB(4'hE), .IO_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
        .addr_bus(addr_bus), .Data_out(Data_out), .Dout_ctrl(Dout_ctrl),
        .Data_in(Data_in), .MIO_ready(MIO_ready),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_be(io_be),
        .io_rdata(io_rdata), .io_ack(io_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  ctrl;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents a request for exactly one accepting edge; returns at accept edge + 1.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] c);
        MemRead = rd; MemWrite = wr; CPU_MIO = 1'b1;
        addr_bus = a; Data_out = d; Dout_ctrl = c;
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0;
    endtask

    // Number of edges until MIO_ready is seen, or -1 when the budget runs out.
    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (MIO_ready) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic ram_op(input string name, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input logic [1:0] c);
        int n;
        do_req(rd, wr, a, d, c);
        wait_ready(n);
        check({name, " latency"}, n, 4);
    endtask

    vec_t vecs[15];
    logic [31:0] last_rd;
    int n, hi, pulses, p1, p2;

    initial begin
        reset_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0;
        addr_bus = '0; Data_out = '0; Dout_ctrl = '0; io_rdata = '0; io_ack = 1'b0;

        vecs[0]  = '{0, 1, 32'h10,   32'h1234_5678, 2'b00, 32'h0};
        vecs[1]  = '{1, 0, 32'h10,   32'h0,         2'b00, 32'h1234_5678};
        vecs[2]  = '{0, 1, 32'h20,   32'hFFFF_FFFF, 2'b00, 32'h0};
        vecs[3]  = '{0, 1, 32'h22,   32'h9999_99AB, 2'b10, 32'h0};
        vecs[4]  = '{0, 1, 32'h20,   32'hFFFF_1234, 2'b01, 32'h0};
        vecs[5]  = '{1, 0, 32'h20,   32'h0,         2'b00, 32'hFFAB_1234};
        vecs[6]  = '{1, 1, 32'h40,   32'h5A5A_5A5A, 2'b00, 32'h0};
        vecs[7]  = '{0, 1, 32'h43,   32'h0000_0077, 2'b10, 32'h0};
        vecs[8]  = '{0, 1, 32'h41,   32'h0000_BEEF, 2'b01, 32'h0};
        vecs[9]  = '{1, 0, 32'h40,   32'h0,         2'b00, 32'h775A_BEEF};
        vecs[10] = '{0, 1, 32'h60,   32'hCAFE_BABE, 2'b11, 32'h0};
        vecs[11] = '{1, 0, 32'h1060, 32'h0,         2'b00, 32'hCAFE_BABE};
        vecs[12] = '{1, 0, 32'h1010, 32'h0,         2'b00, 32'h1234_5678};
        vecs[13] = '{0, 1, 32'h62,   32'h5555_ABCD, 2'b01, 32'h0};
        vecs[14] = '{1, 0, 32'h60,   32'h0,         2'b00, 32'hABCD_BABE};

        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("reset MIO_ready", MIO_ready, 0);
        check("reset io_req",    io_req,    0);
        check("reset io_we",     io_we,     0);
        check("reset Data_in",   Data_in,   0);
        check("reset io_addr",   io_addr,   0);
        check("reset io_wdata",  io_wdata,  0);
        check("reset io_be",     io_be,     0);
        check("reset bus_err",   bus_err,   0);

        // RAM vector table; Data_in must only change on completed reads.
        last_rd = 32'h0;
        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ctrl);
            check($sformatf("vec%0d io_req stays low", i), io_req, 0);
            wait_ready(n);
            check($sformatf("vec%0d latency", i), n, 4);
            if (vecs[i].rd && !vecs[i].wr) last_rd = vecs[i].exp;
            check($sformatf("vec%0d Data_in", i), Data_in, last_rd);
            @(posedge clk); #1;
            check($sformatf("vec%0d MIO_ready one cycle", i), MIO_ready, 0);
        end

        // Requests without CPU_MIO are ignored.
        MemRead = 1'b1; MemWrite = 1'b1; CPU_MIO = 1'b0;
        addr_bus = 32'h40; Data_out = 32'h0; Dout_ctrl = 2'b00;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (MIO_ready) pulses++;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        check("no CPU_MIO no ready", pulses, 0);
        ram_op("rd 0x40 after ignored wr", 1'b1, 1'b0, 32'h40, 32'h0, 2'b00);
        check("0x40 unchanged", Data_in, 32'h775A_BEEF);

        // Back-to-back: a held request is re-accepted in the IDLE cycle after DONE.
        MemRead = 1'b1; CPU_MIO = 1'b1; addr_bus = 32'h10;
        pulses = 0; p1 = -1; p2 = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (MIO_ready) begin
                pulses++;
                if (p1 < 0) p1 = i;
                else begin
                    p2 = i;
                    MemRead = 1'b0; CPU_MIO = 1'b0;
                    break;
                end
            end
        end
        MemRead = 1'b0; CPU_MIO = 1'b0;
        check("b2b first pulse",  p1, 5);
        check("b2b second pulse", p2, 10);
        check("b2b pulse count",  pulses, 2);
        check("b2b Data_in",      Data_in, 32'h1234_5678);
        repeat (3) @(posedge clk); #1;
        check("b2b no third access", MIO_ready, 0);

        // IO read with ack sampled on the fifth edge after accept.
        do_req(1'b1, 1'b0, 32'hE000_0004, 32'h0, 2'b00);
        check("io rd io_addr", io_addr, 32'hE000_0004);
        check("io rd io_be",   io_be,   4'b1111);
        check("io rd io_we",   io_we,   0);
        hi = io_req ? 1 : 0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (io_req) hi++;
            if (MIO_ready) pulses++;
        end
        io_ack = 1'b1; io_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        io_ack = 1'b0; io_rdata = 32'h0;
        if (io_req) hi++;
        if (MIO_ready) pulses++;
        check("io rd io_req cycles", hi, 5);
        check("io rd early ready",   pulses, 0);
        @(posedge clk); #1;
        check("io rd MIO_ready", MIO_ready, 1);
        check("io rd Data_in",   Data_in, 32'hCAFE_F00D);

        // IO byte write: lane replication and byte enable at addr[1:0]=3.
        do_req(1'b0, 1'b1, 32'hF000_0003, 32'h1111_115C, 2'b10);
        check("io wr io_req",   io_req,   1);
        check("io wr io_we",    io_we,    1);
        check("io wr io_be",    io_be,    4'b1000);
        check("io wr io_wdata", io_wdata, 32'h5C5C_5C5C);
        io_ack = 1'b1;
        @(posedge clk); #1;
        io_ack = 1'b0;
        check("io wr io_req dropped", io_req, 0);
        wait_ready(n);
        check("io wr ready latency", n, 1);
        check("io wr Data_in kept",  Data_in, 32'hCAFE_F00D);
        check("bus_err after acked io", bus_err, 0);

        // Reset in RAM_WAIT abandons the pending store.
        ram_op("sw 0 @0x50", 1'b0, 1'b1, 32'h50, 32'h0, 2'b00);
        do_req(1'b0, 1'b1, 32'h50, 32'h0000_0099, 2'b00);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("mid reset MIO_ready", MIO_ready, 0);
        check("mid reset Data_in",   Data_in,   0);
        check("mid reset io_addr",   io_addr,   0);
        check("mid reset io_wdata",  io_wdata,  0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (MIO_ready) pulses++;
        end
        check("abandoned access no ready", pulses, 0);
        ram_op("lw @0x50", 1'b1, 1'b0, 32'h50, 32'h0, 2'b00);
        check("abandoned store not written", Data_in, 32'h0);

`ifdef MIO_TIMEOUT_EN
        // IO read that never gets an ack.
        do_req(1'b1, 1'b0, 32'hE000_0008, 32'h0, 2'b00);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (!io_req) break;
            hi++;
            @(posedge clk); #1;
        end
        check("timeout io_req cycles", hi, 8);
        wait_ready(n);
        check("timeout ready latency", n, 1);
        check("timeout Data_in", Data_in, 32'hDEAD_BEEF);
        check("timeout bus_err", bus_err, 1);
        ram_op("lw after timeout", 1'b1, 1'b0, 32'h10, 32'h0, 2'b00);
        check("bus_err sticky", bus_err, 1);
        @(negedge clk) reset_n = 1'b0;
        #1;
        check("bus_err cleared by reset", bus_err, 0);
        @(negedge clk) reset_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
